// File: rtl/ds_bypass_hazard_unit_pkg.sv
// Shared constants for the decode-stage hazard/bypass block: default widths and
// the producer-index encoding used when scanning forwarding sources.
package ds_bypass_hazard_unit_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int RA_W_DEF      = 5;
  localparam int NSRC_DEF      = 2;
  localparam int NFWD_DEF      = 3;
  localparam int PAYLOAD_W_DEF = 64;
  localparam int CNT_W_DEF     = 16;

  // Producer ordering: lower index is closer to decode and therefore newer.
  localparam int FWD_EX  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

endpackage

// File: rtl/ds_bypass_hazard_unit_fwd_select.sv
// Per-source operand resolver: nearest matching producer wins; an unready
// nearest match blocks the source instead of falling through to older data.
module ds_bypass_hazard_unit_fwd_select
  import ds_bypass_hazard_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF,
  parameter int NFWD = NFWD_DEF
) (
  input  logic                 src_used,
  input  logic [RA_W-1:0]      src_addr,
  input  logic [XLEN-1:0]      rf_rdata,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RA_W-1:0] fwd_dest,
  input  logic [NFWD-1:0]      fwd_ready,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic [XLEN-1:0]      value,
  output logic                 blocked
);

  logic src_live;
  logic found;

  // Register 0 and unused sources never consult producers.
  assign src_live = src_used && (src_addr != '0);

  always_comb begin
    value   = rf_rdata;
    blocked = 1'b0;
    found   = 1'b0;
    for (int i = FWD_EX; i < NFWD; i++) begin
      if (!found && src_live && fwd_valid[i] &&
          (fwd_dest[i*RA_W +: RA_W] == src_addr)) begin
        found = 1'b1;
        if (fwd_ready[i]) begin
          value = fwd_data[i*XLEN +: XLEN];
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ds_bypass_hazard_unit.sv
// Decode stage: IF->ID register with valid/allowin handshake, operand bypass
// over NFWD producers, load-use/multi-cycle stall, and a stall-cycle counter.
module ds_bypass_hazard_unit
  import ds_bypass_hazard_unit_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int RA_W      = RA_W_DEF,
  parameter int NSRC      = NSRC_DEF,
  parameter int NFWD      = NFWD_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fs_to_ds_valid,
  input  logic [PAYLOAD_W-1:0] fs_payload,
  output logic                 ds_allowin,
  input  logic                 es_allowin,
  input  logic                 flush,
  output logic [PAYLOAD_W-1:0] ds_payload,
  input  logic [NSRC-1:0]      src_used,
  input  logic [NSRC*RA_W-1:0] src_addr,
  input  logic                 is_branch,
  input  logic [NSRC*XLEN-1:0] rf_rdata,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RA_W-1:0] fwd_dest,
  input  logic [NFWD-1:0]      fwd_ready,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic [NSRC*XLEN-1:0] src_value,
  output logic                 ds_to_es_valid,
  output logic                 hazard_stall,
  output logic                 br_stall,
  input  logic                 perf_clr,
  output logic [CNT_W-1:0]     stall_cycles
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic                 vld_p0;
  logic [PAYLOAD_W-1:0] payload_p0;
  logic [CNT_W-1:0]     stall_cnt;
  logic [NSRC-1:0]      src_blocked;
  logic                 ds_ready_go;
  logic                 accept;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    ds_bypass_hazard_unit_fwd_select #(
      .XLEN (XLEN),
      .RA_W (RA_W),
      .NFWD (NFWD)
    ) u_sel (
      .src_used  (src_used[s]),
      .src_addr  (src_addr[s*RA_W +: RA_W]),
      .rf_rdata  (rf_rdata[s*XLEN +: XLEN]),
      .fwd_valid (fwd_valid),
      .fwd_dest  (fwd_dest),
      .fwd_ready (fwd_ready),
      .fwd_data  (fwd_data),
      .value     (src_value[s*XLEN +: XLEN]),
      .blocked   (src_blocked[s])
    );
  end

  assign hazard_stall   = vld_p0 && (|src_blocked);
  assign ds_ready_go    = !hazard_stall;
  assign ds_allowin     = !vld_p0 || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = vld_p0 && ds_ready_go && !flush;
  assign br_stall       = vld_p0 && is_branch && hazard_stall;
  assign accept         = fs_to_ds_valid && ds_allowin && !flush;

  // IF -> ID stage boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (ds_allowin) begin
      vld_p0 <= fs_to_ds_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      payload_p0 <= '0;
    end else if (accept) begin
      payload_p0 <= fs_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || perf_clr) begin
      stall_cnt <= '0;
    end else if (hazard_stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign ds_payload   = payload_p0;
  assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_ds_bypass_hazard_unit.sv
// Bench for ds_bypass_hazard_unit: directed cycle table, hand sequences for
// saturation/reset-mid-stall, then randomized traffic against a reference model.
module tb_ds_bypass_hazard_unit;

  localparam logic [63:0] PB = 64'h0000_0001_BFC0_0000;
  localparam logic [14:0] D7 = 15'd7;
  localparam logic [14:0] D555 = {5'd5, 5'd5, 5'd5};

  logic        clk = 1'b0;
  logic        reset;
  logic        fs_to_ds_valid;
  logic [63:0] fs_payload;
  logic        ds_allowin;
  logic        es_allowin;
  logic        flush;
  logic [63:0] ds_payload;
  logic [1:0]  src_used;
  logic [9:0]  src_addr;
  logic        is_branch;
  logic [63:0] rf_rdata;
  logic [2:0]  fwd_valid;
  logic [14:0] fwd_dest;
  logic [2:0]  fwd_ready;
  logic [95:0] fwd_data;
  logic [63:0] src_value;
  logic        ds_to_es_valid;
  logic        hazard_stall;
  logic        br_stall;
  logic        perf_clr;
  logic [3:0]  stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  ds_bypass_hazard_unit #(
    .XLEN(32), .RA_W(5), .NSRC(2), .NFWD(3), .PAYLOAD_W(64), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .fs_to_ds_valid(fs_to_ds_valid), .fs_payload(fs_payload),
    .ds_allowin(ds_allowin), .es_allowin(es_allowin), .flush(flush), .ds_payload(ds_payload),
    .src_used(src_used), .src_addr(src_addr), .is_branch(is_branch), .rf_rdata(rf_rdata),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
    .src_value(src_value), .ds_to_es_valid(ds_to_es_valid), .hazard_stall(hazard_stall),
    .br_stall(br_stall), .perf_clr(perf_clr), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fsv;
    logic [63:0] pay;
    logic        esa;
    logic        fl;
    logic [1:0]  used;
    logic [4:0]  a0;
    logic [2:0]  fv;
    logic [14:0] dests;
    logic [2:0]  rdy;
    logic        br;
    logic        pclr;
    logic [31:0] rf0;
    logic        e_aw;
    logic        e_tov;
    logic        e_hz;
    logic        e_br;
    logic        chk_v;
    logic [31:0] e_v0;
    logic [63:0] e_pay;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    fs_to_ds_valid = 1'b0;
    fs_payload     = '0;
    es_allowin     = 1'b1;
    flush          = 1'b0;
    src_used       = '0;
    src_addr       = '0;
    is_branch      = 1'b0;
    rf_rdata       = {32'hBBBB_0001, 32'h0000_1234};
    fwd_valid      = '0;
    fwd_dest       = '0;
    fwd_ready      = '0;
    fwd_data       = {32'h33, 32'h22, 32'h11};
    perf_clr       = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic aw, input logic tov, input logic hz,
                            input logic br, input logic [63:0] pay, input logic [3:0] cnt);
    chk({tag, " ds_allowin"}, ds_allowin, aw);
    chk({tag, " ds_to_es_valid"}, ds_to_es_valid, tov);
    chk({tag, " hazard_stall"}, hazard_stall, hz);
    chk({tag, " br_stall"}, br_stall, br);
    chk({tag, " ds_payload"}, ds_payload, pay);
    chk({tag, " stall_cycles"}, stall_cycles, cnt);
  endtask

  // Reference model state
  logic        m_vld;
  logic [63:0] m_pay;
  int          m_cnt;

  initial begin
    // fsv pay esa fl used a0 fv dests rdy br pclr rf0 | aw tov hz br chkv v0 pay cnt
    vecs.push_back('{0, 64'd0,   1, 0, 2'b00, 5'd0, 3'b000, 15'd0, 3'b000, 0, 0, 32'h1234, 1, 0, 0, 0, 1, 32'h1234, 64'd0, 4'd0});
    vecs.push_back('{1, PB,      1, 0, 2'b00, 5'd0, 3'b000, 15'd0, 3'b000, 0, 0, 32'h1234, 1, 0, 0, 0, 1, 32'h1234, 64'd0, 4'd0});
    vecs.push_back('{1, PB+4,    1, 0, 2'b11, 5'd3, 3'b000, 15'd0, 3'b000, 0, 0, 32'hCAFE, 1, 1, 0, 0, 1, 32'hCAFE, PB, 4'd0});
    vecs.push_back('{1, PB+8,    1, 0, 2'b01, 5'd5, 3'b111, D555,  3'b111, 0, 0, 32'hCAFE, 1, 1, 0, 0, 1, 32'h11, PB+4, 4'd0});
    vecs.push_back('{1, PB+12,   1, 0, 2'b01, 5'd5, 3'b110, D555,  3'b111, 0, 0, 32'hCAFE, 1, 1, 0, 0, 1, 32'h22, PB+8, 4'd0});
    vecs.push_back('{1, PB+16,   1, 0, 2'b01, 5'd7, 3'b001, D7,    3'b000, 0, 0, 32'hCAFE, 0, 0, 1, 0, 0, 32'h0, PB+12, 4'd0});
    vecs.push_back('{1, PB+16,   1, 0, 2'b01, 5'd7, 3'b001, D7,    3'b000, 0, 0, 32'hCAFE, 0, 0, 1, 0, 0, 32'h0, PB+12, 4'd1});
    vecs.push_back('{1, PB+16,   1, 0, 2'b01, 5'd7, 3'b001, D7,    3'b001, 0, 0, 32'hCAFE, 1, 1, 0, 0, 1, 32'h11, PB+12, 4'd2});
    vecs.push_back('{1, PB+20,   1, 0, 2'b01, 5'd0, 3'b001, 15'd0, 3'b000, 0, 0, 32'h0,    1, 1, 0, 0, 1, 32'h0, PB+16, 4'd2});
    vecs.push_back('{1, PB+24,   1, 0, 2'b01, 5'd7, 3'b001, D7,    3'b000, 1, 0, 32'hCAFE, 0, 0, 1, 1, 0, 32'h0, PB+20, 4'd2});
    vecs.push_back('{1, PB+24,   1, 1, 2'b01, 5'd7, 3'b001, D7,    3'b000, 1, 0, 32'hCAFE, 0, 0, 1, 1, 0, 32'h0, PB+20, 4'd3});
    vecs.push_back('{0, 64'd0,   1, 0, 2'b01, 5'd7, 3'b001, D7,    3'b000, 1, 0, 32'hCAFE, 1, 0, 0, 0, 0, 32'h0, PB+20, 4'd4});
    vecs.push_back('{1, PB+28,   1, 0, 2'b00, 5'd0, 3'b000, 15'd0, 3'b000, 0, 1, 32'hCAFE, 1, 0, 0, 0, 1, 32'hCAFE, PB+20, 4'd4});
    vecs.push_back('{0, 64'd0,   0, 0, 2'b00, 5'd0, 3'b000, 15'd0, 3'b000, 0, 0, 32'hCAFE, 0, 1, 0, 0, 1, 32'hCAFE, PB+28, 4'd0});
    vecs.push_back('{1, PB+32,   1, 1, 2'b00, 5'd0, 3'b000, 15'd0, 3'b000, 0, 0, 32'hCAFE, 1, 0, 0, 0, 1, 32'hCAFE, PB+28, 4'd0});
    vecs.push_back('{0, 64'd0,   1, 0, 2'b00, 5'd0, 3'b000, 15'd0, 3'b000, 0, 0, 32'hCAFE, 1, 0, 0, 0, 1, 32'hCAFE, PB+28, 4'd0});

    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed cycle table
    foreach (vecs[r]) begin
      fs_to_ds_valid = vecs[r].fsv;
      fs_payload     = vecs[r].pay;
      es_allowin     = vecs[r].esa;
      flush          = vecs[r].fl;
      src_used       = vecs[r].used;
      src_addr       = {5'd0, vecs[r].a0};
      fwd_valid      = vecs[r].fv;
      fwd_dest       = vecs[r].dests;
      fwd_ready      = vecs[r].rdy;
      is_branch      = vecs[r].br;
      perf_clr       = vecs[r].pclr;
      rf_rdata       = {32'hBBBB_0001, vecs[r].rf0};
      #1;
      check_outs($sformatf("row%0d", r), vecs[r].e_aw, vecs[r].e_tov, vecs[r].e_hz,
                 vecs[r].e_br, vecs[r].e_pay, vecs[r].e_cnt);
      if (vecs[r].chk_v) chk($sformatf("row%0d src_value0", r), src_value[31:0], vecs[r].e_v0);
      tick();
    end

    // Saturation: 20 stalled cycles on a 4-bit counter
    drive_idle();
    fs_to_ds_valid = 1'b1;
    fs_payload     = PB + 64'd100;
    src_used       = 2'b01;
    src_addr       = 10'd7;
    fwd_valid      = 3'b001;
    fwd_dest       = D7;
    fwd_ready      = 3'b000;
    tick();
    fs_to_ds_valid = 1'b0;
    repeat (20) tick();
    #1;
    check_outs("sat", 1'b0, 1'b0, 1'b1, 1'b0, PB + 64'd100, 4'd15);
    perf_clr = 1'b1;
    tick();
    #1;
    check_outs("clr_over_inc", 1'b0, 1'b0, 1'b1, 1'b0, PB + 64'd100, 4'd0);
    perf_clr = 1'b0;
    tick();
    #1;
    chk("inc_after_clr stall_cycles", stall_cycles, 4'd1);

    // Reset in the middle of a stall
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_outs("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    fs_to_ds_valid = 1'b1;
    fs_payload     = PB + 64'd200;
    fwd_ready      = 3'b001;
    tick();
    fs_to_ds_valid = 1'b0;
    #1;
    check_outs("restart", 1'b1, 1'b1, 1'b0, 1'b0, PB + 64'd200, 4'd0);
    chk("restart src_value0", src_value[31:0], 32'h11);

    // Randomized traffic against the reference model
    drive_idle();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    m_vld  = 1'b0;
    m_pay  = '0;
    m_cnt  = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic        any_blk, e_hz, e_aw, e_tov, e_br;
      logic [2:0]  mask, low;
      int          idx;
      logic [31:0] ev;
      reset          = ($urandom_range(0, 199) == 0);
      fs_to_ds_valid = ($urandom_range(0, 2) != 0);
      fs_payload     = {$urandom, $urandom};
      es_allowin     = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 15) == 0);
      perf_clr       = ($urandom_range(0, 31) == 0);
      is_branch      = $urandom_range(0, 1);
      src_used       = $urandom_range(0, 3);
      src_addr       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rf_rdata       = {$urandom, $urandom};
      fwd_valid      = $urandom_range(0, 7);
      fwd_dest       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      for (int i = 0; i < 3; i++) fwd_ready[i] = ($urandom_range(0, 3) != 0);
      fwd_data       = {$urandom, $urandom, $urandom};
      #1;
      any_blk = 1'b0;
      for (int s = 0; s < 2; s++) begin
        logic [4:0] a;
        a    = src_addr[s*5 +: 5];
        mask = '0;
        for (int i = 0; i < 3; i++)
          mask[i] = src_used[s] && (a != 0) && fwd_valid[i] && (fwd_dest[i*5 +: 5] == a);
        if (mask == 0) begin
          chk($sformatf("rnd%0d src%0d rf", cyc, s), src_value[s*32 +: 32], rf_rdata[s*32 +: 32]);
        end else begin
          low = mask & (~mask + 3'd1);
          idx = $clog2(low);
          if (fwd_ready[idx]) begin
            ev = fwd_data[idx*32 +: 32];
            chk($sformatf("rnd%0d src%0d fwd", cyc, s), src_value[s*32 +: 32], ev);
          end else begin
            any_blk = 1'b1;
          end
        end
      end
      e_hz  = m_vld && any_blk;
      e_aw  = !m_vld || (!e_hz && es_allowin);
      e_tov = m_vld && !e_hz && !flush;
      e_br  = m_vld && is_branch && e_hz;
      check_outs($sformatf("rnd%0d", cyc), e_aw, e_tov, e_hz, e_br, m_pay, 4'(m_cnt));
      if (reset) begin
        m_vld = 1'b0;
        m_pay = '0;
        m_cnt = 0;
      end else begin
        if (perf_clr) m_cnt = 0;
        else if (e_hz && m_cnt < 15) m_cnt = m_cnt + 1;
        if (fs_to_ds_valid && e_aw && !flush) m_pay = fs_payload;
        if (flush) m_vld = 1'b0;
        else if (e_aw) m_vld = fs_to_ds_valid;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ds_bypass_hazard_unit.md
Name: ds_bypass_hazard_unit

Overview:
Parametrised decode-stage hazard and bypass block. It holds the IF→ID pipeline register and its valid/allowin handshake. It resolves NSRC source operands against NFWD downstream producers using nearest-stage-first forwarding, and stalls on any producer whose result is not yet available (load, multi-cycle ops). It sits between the fetch stage and the instruction decoder/execute interface, and adds flush and stall-cycle performance counting.

Parameters:
XLEN, 32, operand/result width
RA_W, 5, register address width; address 0 is hardwired zero
NSRC, 2, number of source operands per instruction
NFWD, 3, number of forwarding producers; index 0 = nearest (EX), NFWD-1 = farthest (WB)
PAYLOAD_W, 64, fetch-to-decode bus width ({inst, pc})
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fs_to_ds_valid  in  1  fetch payload valid
fs_payload  in  PAYLOAD_W  fetch payload
ds_allowin  out  1  decode can accept this cycle
es_allowin  in  1  execute can accept
flush  in  1  discard the instruction held in decode (exception/redirect)
ds_payload  out  PAYLOAD_W  registered payload, fed to the external decoder
src_used  in  NSRC  per-source "operand read from regfile" (from decoder)
src_addr  in  NSRC*RA_W  per-source register address (from decoder)
is_branch  in  1  held instruction resolves a branch in decode
rf_rdata  in  NSRC*XLEN  regfile read data per source
fwd_valid  in  NFWD  producer holds a valid register-writing instruction
fwd_dest  in  NFWD*RA_W  producer destination register
fwd_ready  in  NFWD  producer result available this cycle
fwd_data  in  NFWD*XLEN  producer result
src_value  out  NSRC*XLEN  resolved operand values
ds_to_es_valid  out  1  valid, ready-to-go instruction toward execute
hazard_stall  out  1  decode stalled on an unready producer
br_stall  out  1  branch cannot resolve this cycle
perf_clr  in  1  clear stall counter
stall_cycles  out  CNT_W  saturating count of stalled valid cycles

Behaviour:
- Reset values: ds_valid=0, ds_payload=0, stall_cycles=0. Hence ds_to_es_valid=0, hazard_stall=0, br_stall=0, ds_allowin=1.
- Forwarding match for source s against producer i: src_used[s] & src_addr[s]!=0 & fwd_valid[i] & fwd_dest[i]==src_addr[s]. A fwd_dest of 0 never matches.
- Selection: the lowest matching index i wins. If fwd_ready[i]=1, src_value[s]=fwd_data[i]. If fwd_ready[i]=0, the source is blocked, and farther producers are not consulted (they hold stale values).
- No match: src_value[s]=rf_rdata[s]. Address 0: rf_rdata (regfile returns 0).
- hazard_stall = ds_valid & (any source blocked). ds_ready_go = ~hazard_stall.
- ds_allowin = ~ds_valid | (ds_ready_go & es_allowin). ds_to_es_valid = ds_valid & ds_ready_go & ~flush.
- Sequential update, priority order reset > flush > accept:
  - flush: ds_valid←0 for the next cycle.
  - Otherwise, if ds_allowin: ds_valid←fs_to_ds_valid.
  - ds_payload loads when fs_to_ds_valid & ds_allowin & ~flush.
- Latency: payload accepted in cycle N is visible on ds_payload in cycle N+1. Operand resolution is combinational in the same cycle.
- br_stall = ds_valid & is_branch & hazard_stall. Fetch must not consume a branch target while br_stall=1.
- Stall counter: increments when hazard_stall=1, saturates at 2^CNT_W-1. perf_clr clears it; perf_clr takes priority over increment.
- Simultaneous: a flush while stalled drops the instruction. ds_allowin reflects the pre-flush state in the flush cycle, and the held instruction is not forwarded.
- Reset mid-stall: the counter and valid bit clear, and the handshake restarts accepting on the next cycle.

Decomposition:
- Shared package: XLEN, RA_W, default NFWD/NSRC, and a producer-index encoding constant (FWD_EX=0, FWD_MEM=1, FWD_WB=2).
- One natural sub-module, fwd_select: per-source priority match and mux over NFWD producers, instantiated NSRC times via generate. It outputs value and blocked.

Test Plan:
- Basic: fs_payload=0x0000_0001_BFC0_0000 with es_allowin=1 → ds_payload equals it one cycle later, ds_to_es_valid=1, and src_value = rf_rdata when no fwd_valid is set.
- Priority: src_addr[0]=5; producers 0, 1 and 2 all match with data 0x11, 0x22, 0x33, all ready → src_value[0]=0x11. With producer 0 invalid → 0x22.
- Load-use: producer 0 matches r7 with fwd_ready=0 for 2 cycles → hazard_stall=1, ds_allowin=0, ds_to_es_valid=0 for 2 cycles, stall_cycles=2. On the third cycle it forwards fwd_data[0].
- Zero register: src_addr=0 while producer 0 has dest 0, not ready → no stall, src_value=rf_rdata (0).
- Branch and flush: is_branch=1 under the load-use stall → br_stall=1. Asserting flush that cycle → ds_valid=0 next cycle and ds_to_es_valid never asserts for that instruction.
- Saturation: CNT_W=4 with 20 stalled cycles → stall_cycles=15. perf_clr together with a stall → stall_cycles=0.
